// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a 16-bit
// word-organised data memory. Word accesses go straight through; byte loads
// select and extend a lane; byte stores run a read-modify-write of the
// containing word. Misaligned word accesses are rejected with a one-cycle
// error pulse and never touch memory.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        C_MemReq,
    input  logic        C_MemWe,
    input  logic        C_MemByte,
    input  logic        C_MemSignExt,
    input  logic [15:0] A_ByteAddress,
    input  logic [15:0] D_StoreData,
    output logic        C_MemBusy,
    output logic        C_LoadValid,
    output logic [15:0] D_LoadData,
    output logic        C_MisalignErr,
    output logic [15:0] A_DataAddress,
    output logic [15:0] D_WriteData,
    output logic        C_DMRead,
    output logic        C_DMWrite,
    input  logic [15:0] D_Data
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;

    logic [2:0]  state;
    logic [2:0]  next_state;

    // request fields captured at acceptance; the requester may change its
    // inputs freely once the access is under way
    logic        lane_q;     // byte lane: 0 = bits [7:0], 1 = bits [15:8]
    logic        byte_q;
    logic        sext_q;
    logic [7:0]  sbyte_q;    // byte to merge during RMW_WR

    logic        accept;
    logic        misalign_req;
    logic [7:0]  sel_byte;
    logic [15:0] load_fmt;
    logic [15:0] merged;

    // a request is only looked at while idle
    assign accept       = (state == IDLE) && C_MemReq;
    assign misalign_req = !C_MemByte && A_ByteAddress[0];

    // memory strobes decoded straight from the state, so they are never both
    // high and both are low in IDLE
    assign C_MemBusy = (state != IDLE);
    assign C_DMRead  = (state == RD) || (state == RMW_RD);
    assign C_DMWrite = (state == WR) || (state == RMW_WR);

    // lane select, load formatting and byte merge on the returned word
    always_comb begin
        sel_byte = lane_q ? D_Data[15:8] : D_Data[7:0];
        if (byte_q)
            load_fmt = {(sext_q && sel_byte[7]) ? 8'hFF : 8'h00, sel_byte};
        else
            load_fmt = D_Data;
        merged = lane_q ? {sbyte_q, D_Data[7:0]} : {D_Data[15:8], sbyte_q};
    end

    // next-state decode; misaligned word requests leave the FSM in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (C_MemReq && !misalign_req) begin
                    if (!C_MemWe)
                        next_state = RD;
                    else if (C_MemByte)
                        next_state = RMW_RD;
                    else
                        next_state = WR;
                end
            end
            RD:      next_state = IDLE;
            WR:      next_state = IDLE;
            RMW_RD:  next_state = RMW_WR;
            RMW_WR:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // state register and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            C_LoadValid   <= 1'b0;
            C_MisalignErr <= 1'b0;
        end else begin
            state         <= next_state;
            C_LoadValid   <= (state == RD);
            C_MisalignErr <= accept && misalign_req;
        end
    end

    // request field capture at acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            A_DataAddress <= 16'h0000;
            lane_q        <= 1'b0;
            byte_q        <= 1'b0;
            sext_q        <= 1'b0;
            sbyte_q       <= 8'h00;
        end else if (accept) begin
            // bit 15 is always 0: the 64 KiB byte space maps to 32 Ki words
            A_DataAddress <= {1'b0, A_ByteAddress[15:1]};
            lane_q        <= A_ByteAddress[0];
            byte_q        <= C_MemByte;
            sext_q        <= C_MemSignExt;
            sbyte_q       <= D_StoreData[7:0];
        end
    end

    // write word: taken directly for a word store, rebuilt from the read word
    // at the end of RMW_RD for a byte store
    always_ff @(posedge clk) begin
        if (!rst)
            D_WriteData <= 16'h0000;
        else if (accept && C_MemWe && !C_MemByte)
            D_WriteData <= D_StoreData;
        else if (state == RMW_RD)
            D_WriteData <= merged;
    end

    // load result captured at the end of RD and held until the next load
    always_ff @(posedge clk) begin
        if (!rst)
            D_LoadData <= 16'h0000;
        else if (state == RD)
            D_LoadData <= load_fmt;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a data memory around the DUT, a byte-addressed
// reference memory for expected values, a table of directed accesses,
// hand-written reset/back-to-back sequences and a randomized run.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        C_MemReq, C_MemWe, C_MemByte, C_MemSignExt;
    logic [15:0] A_ByteAddress, D_StoreData;
    logic        C_MemBusy, C_LoadValid, C_MisalignErr, C_DMRead, C_DMWrite;
    logic [15:0] D_LoadData, A_DataAddress, D_WriteData, D_Data;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .C_MemReq(C_MemReq), .C_MemWe(C_MemWe), .C_MemByte(C_MemByte),
        .C_MemSignExt(C_MemSignExt), .A_ByteAddress(A_ByteAddress),
        .D_StoreData(D_StoreData), .C_MemBusy(C_MemBusy),
        .C_LoadValid(C_LoadValid), .D_LoadData(D_LoadData),
        .C_MisalignErr(C_MisalignErr), .A_DataAddress(A_DataAddress),
        .D_WriteData(D_WriteData), .C_DMRead(C_DMRead), .C_DMWrite(C_DMWrite),
        .D_Data(D_Data)
    );

    // data memory seen by the DUT
    logic [15:0] mem [0:65535];
    assign D_Data = C_DMRead ? mem[A_DataAddress] : 16'h0000;
    always @(posedge clk) if (C_DMWrite) mem[A_DataAddress] <= D_WriteData;

    // reference model: plain byte-addressed little-endian memory
    logic [7:0] ref_b [0:65535];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] wa);
        return {ref_b[{wa[14:0], 1'b1}], ref_b[{wa[14:0], 1'b0}]};
    endfunction

    function automatic logic [15:0] ref_load(input logic bt, input logic sx, input logic [15:0] a);
        logic [7:0] b;
        if (!bt) return {ref_b[a | 16'h0001], ref_b[a & 16'hFFFE]};
        b = ref_b[a];
        return sx ? 16'($signed(b)) : {8'h00, b};
    endfunction

    task automatic ref_store(input logic bt, input logic [15:0] a, input logic [15:0] d);
        ref_b[a] = d[7:0];
        if (!bt) ref_b[a | 16'h0001] = d[15:8];
    endtask

    // garbage on the request inputs while the DUT is busy
    task automatic scramble();
        C_MemReq      = 1'($urandom);
        C_MemWe       = 1'($urandom);
        C_MemByte     = 1'($urandom);
        C_MemSignExt  = 1'($urandom);
        A_ByteAddress = 16'($urandom);
        D_StoreData   = 16'($urandom);
    endtask

    // never both strobes in one cycle
    always @(negedge clk) begin
        if (C_DMRead && C_DMWrite) begin
            errs++;
            $display("FAIL strobe_overlap: rd=%b wr=%b", C_DMRead, C_DMWrite);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  16'(C_MemBusy), 16'h0);
        chk({tag, "_valid"}, 16'(C_LoadValid), 16'h0);
        chk({tag, "_mis"},   16'(C_MisalignErr), 16'h0);
        chk({tag, "_rd"},    16'(C_DMRead), 16'h0);
        chk({tag, "_wr"},    16'(C_DMWrite), 16'h0);
        chk({tag, "_ldata"}, D_LoadData, 16'h0);
        chk({tag, "_addr"},  A_DataAddress, 16'h0);
        chk({tag, "_wdata"}, D_WriteData, 16'h0);
    endtask

    // one complete access; entered and left at a negedge with the DUT idle
    task automatic access(input logic we, input logic bt, input logic sx,
                          input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] ld);
        logic [15:0] wa;
        logic [15:0] exp;
        wa = {1'b0, a[15:1]};
        ld = 16'h0000;
        C_MemReq = 1'b1; C_MemWe = we; C_MemByte = bt; C_MemSignExt = sx;
        A_ByteAddress = a; D_StoreData = d;
        @(posedge clk); @(negedge clk);
        if (!bt && a[0]) begin
            C_MemReq = 1'b0;
            chk("mis_pulse", 16'(C_MisalignErr), 16'h1);
            chk("mis_busy",  16'(C_MemBusy), 16'h0);
            chk("mis_rd",    16'(C_DMRead), 16'h0);
            chk("mis_wr",    16'(C_DMWrite), 16'h0);
            @(negedge clk);
            chk("mis_clear", 16'(C_MisalignErr), 16'h0);
            return;
        end
        scramble();
        chk("acc_busy", 16'(C_MemBusy), 16'h1);
        chk("acc_addr", A_DataAddress, wa);
        if (!we) begin
            exp = ref_load(bt, sx, a);
            chk("ld_rd", 16'(C_DMRead), 16'h1);
            chk("ld_wr", 16'(C_DMWrite), 16'h0);
            @(negedge clk);
            C_MemReq = 1'b0;
            chk("ld_valid", 16'(C_LoadValid), 16'h1);
            chk("ld_idle",  16'(C_MemBusy), 16'h0);
            chk("ld_data",  D_LoadData, exp);
            ld = D_LoadData;
            @(negedge clk);
            chk("ld_pulse_end", 16'(C_LoadValid), 16'h0);
            chk("ld_hold",      D_LoadData, exp);
        end else if (!bt) begin
            ref_store(1'b0, a, d);
            chk("ws_wr",    16'(C_DMWrite), 16'h1);
            chk("ws_wdata", D_WriteData, ref_word(wa));
            @(negedge clk);
            C_MemReq = 1'b0;
            chk("ws_idle", 16'(C_MemBusy), 16'h0);
            chk("ws_mem",  mem[wa], ref_word(wa));
        end else begin
            chk("rmw_rd",    16'(C_DMRead), 16'h1);
            chk("rmw_rd_wr", 16'(C_DMWrite), 16'h0);
            ref_store(1'b1, a, d);
            @(negedge clk);
            scramble();
            chk("rmw2_busy",  16'(C_MemBusy), 16'h1);
            chk("rmw2_wr",    16'(C_DMWrite), 16'h1);
            chk("rmw2_addr",  A_DataAddress, wa);
            chk("rmw2_wdata", D_WriteData, ref_word(wa));
            @(negedge clk);
            C_MemReq = 1'b0;
            chk("rmw_idle", 16'(C_MemBusy), 16'h0);
            chk("rmw_mem",  mem[wa], ref_word(wa));
        end
    endtask

    typedef struct {
        logic        we, bt, sx;
        logic [15:0] a, d, exp;
        logic        cmp;   // compare load result against exp
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [15:0] ld;
        logic [15:0] e;
        for (int i = 0; i < 65536; i++) begin mem[i] = 16'h0; ref_b[i] = 8'h0; end
        rst = 1'b0; C_MemReq = 1'b0; C_MemWe = 1'b0; C_MemByte = 1'b0;
        C_MemSignExt = 1'b0; A_ByteAddress = 16'h0; D_StoreData = 16'h0;

        //           we    bt    sx    addr      data      expected   cmp
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h80F1, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'hFF80, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0080, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'hFFF1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'hBB5A, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5A34, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hA500, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFA5, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 13; i++) begin
            access(tbl[i].we, tbl[i].bt, tbl[i].sx, tbl[i].a, tbl[i].d, ld);
            if (tbl[i].cmp) chk($sformatf("tbl%0d_load", i), ld, tbl[i].exp);
        end

        // reset during RMW_RD of a byte store aborts without writing
        access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, ld);
        C_MemReq = 1'b1; C_MemWe = 1'b1; C_MemByte = 1'b1; A_ByteAddress = 16'h0010;
        D_StoreData = 16'h0077;
        @(posedge clk); @(negedge clk);
        chk("abort_in_rmw_rd", 16'(C_DMRead), 16'h1);
        C_MemReq = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        chk_all_zero("abort_rmw");
        @(negedge clk);
        chk_all_zero("abort_rmw_next");
        chk("abort_rmw_mem", mem[16'h0008], 16'h1234);

        // reset during RD suppresses the load pulse
        C_MemReq = 1'b1; C_MemWe = 1'b0; C_MemByte = 1'b0; A_ByteAddress = 16'h0010;
        @(posedge clk); @(negedge clk);
        chk("abort_in_rd", 16'(C_DMRead), 16'h1);
        C_MemReq = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rd_valid", 16'(C_LoadValid), 16'h0);

        // load then store with the request held high: store waits out the
        // load and is taken in the C_LoadValid cycle
        C_MemReq = 1'b1; C_MemWe = 1'b0; C_MemByte = 1'b0; A_ByteAddress = 16'h0010;
        @(posedge clk); @(negedge clk);
        e = ref_load(1'b0, 1'b0, 16'h0010);
        chk("b2b_rd", 16'(C_DMRead), 16'h1);
        C_MemWe = 1'b1; A_ByteAddress = 16'h0020; D_StoreData = 16'h7777;
        @(posedge clk); @(negedge clk);
        chk("b2b_valid", 16'(C_LoadValid), 16'h1);
        chk("b2b_ldata", D_LoadData, e);
        chk("b2b_no_early_wr", 16'(C_DMWrite), 16'h0);
        chk("b2b_no_early_busy", 16'(C_MemBusy), 16'h0);
        @(posedge clk); @(negedge clk);
        C_MemReq = 1'b0;
        ref_store(1'b0, 16'h0020, 16'h7777);
        chk("b2b_st_wr", 16'(C_DMWrite), 16'h1);
        chk("b2b_st_addr", A_DataAddress, 16'h0010);
        chk("b2b_st_wdata", D_WriteData, 16'h7777);
        @(negedge clk);
        chk("b2b_st_idle", 16'(C_MemBusy), 16'h0);
        chk("b2b_st_mem", mem[16'h0010], ref_word(16'h0010));
        // memory word 8 still holds the earlier 0x1234 in the model too
        chk("b2b_w8_mem", mem[16'h0008], ref_word(16'h0008));

        // randomized accesses against the reference model
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = {10'h0, 6'($urandom)};
            if ($urandom_range(0, 3) == 0) a = a | 16'hFFC0;
            access(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), ld);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
